// File: rtl/opll_seq_pkg.sv
// Shared constants and types for the OPLL write sequencer.
// FSM state codes, default bus timing, and the queued write record.
package opll_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;

    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_WR_LOW     = 8;
    localparam int DEF_ADDR_WAIT  = 12;
    localparam int DEF_DATA_WAIT  = 84;

    localparam int OPLL_SHADOW_REGS = 64;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } opll_wr_t;

endpackage

// File: rtl/opll_write_sequencer_if.sv
// Host-side write request handshake into the OPLL write sequencer.
interface opll_write_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/opll_seq_fifo.sv
// Synchronous FIFO of {addr,data} write records; a push while full is dropped
// even if a pop happens on the same edge.
module opll_seq_fifo
    import opll_seq_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  opll_wr_t      push_data,
    input  logic          pop,
    output opll_wr_t      head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int PW = $clog2(DEPTH);

    opll_wr_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic            do_push;
    logic            do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_reg;
    // Head is read combinationally so the sequencer can latch it on the pop edge.
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/opll_write_sequencer.sv
// Replays queued OPLL register writes as address then data bus cycles with YM2413 waits.
// Optional register shadow enabled by defining OPLL_SEQ_SHADOW_EN.
module opll_write_sequencer
    import opll_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int WR_LOW     = DEF_WR_LOW,
    parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter int DATA_WAIT  = DEF_DATA_WAIT
) (
    input  logic                        clk,
    input  logic                        reset,
    opll_write_sequencer_if.slave       req,
    output logic                        opll_cs_n,
    output logic                        opll_wr_n,
    output logic                        opll_a0,
    output logic [7:0]                  opll_d,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic [5:0]                  rd_addr,
    output logic [7:0]                  rd_data
);
    localparam int CNT_MAX = (DATA_WAIT > ADDR_WAIT)
                           ? ((DATA_WAIT > WR_LOW) ? DATA_WAIT : WR_LOW)
                           : ((ADDR_WAIT > WR_LOW) ? ADDR_WAIT : WR_LOW);
    localparam int CW = $clog2(CNT_MAX + 1);

    logic [2:0]    state_reg;
    logic          ph_reg;
    logic [7:0]    a_reg;
    logic [7:0]    d_reg;
    logic [CW-1:0] cnt_reg;
    logic          cs_n_reg;
    logic          wr_n_reg;
    logic          a0_reg;
    logic [7:0]    d_out_reg;

    opll_wr_t push_entry;
    opll_wr_t head;
    logic     full;
    logic     empty;
    logic     pop;
    logic     cnt_last;

    assign push_entry = '{addr: req.req_addr, data: req.req_data};
    assign req.req_ready = !full;
    assign cnt_last = (cnt_reg == CW'(1));
    // The next entry is taken from IDLE, or straight out of a finished data wait
    // so back-to-back pairs run without an IDLE gap.
    assign pop = !empty && ((state_reg == ST_IDLE) ||
                            (state_reg == ST_WAIT && cnt_last && ph_reg));

    opll_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req.req_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ph_reg    <= 1'b0;
            a_reg     <= '0;
            d_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        a_reg     <= head.addr;
                        d_reg     <= head.data;
                        ph_reg    <= 1'b0;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt_reg   <= CW'(WR_LOW);
                    state_reg <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt_last) state_reg <= ST_HOLD;
                    else          cnt_reg   <= cnt_reg - 1'b1;
                end
                ST_HOLD: begin
                    cnt_reg   <= ph_reg ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!cnt_last) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (!ph_reg) begin
                        ph_reg    <= 1'b1;
                        state_reg <= ST_SETUP;
                    end else if (pop) begin
                        a_reg     <= head.addr;
                        d_reg     <= head.data;
                        ph_reg    <= 1'b0;
                        state_reg <= ST_SETUP;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Pins are a registered decode of the state, so each bus phase trails its state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_reg  <= 1'b1;
            wr_n_reg  <= 1'b1;
            a0_reg    <= 1'b0;
            d_out_reg <= '0;
        end else begin
            cs_n_reg <= !((state_reg == ST_SETUP) || (state_reg == ST_STROBE) ||
                          (state_reg == ST_HOLD));
            wr_n_reg <= (state_reg != ST_STROBE);
            if (state_reg == ST_SETUP) begin
                a0_reg    <= ph_reg;
                d_out_reg <= ph_reg ? d_reg : a_reg;
            end
        end
    end

    assign opll_cs_n = cs_n_reg;
    assign opll_wr_n = wr_n_reg;
    assign opll_a0   = a0_reg;
    assign opll_d    = d_out_reg;
    assign busy      = !empty || (state_reg != ST_IDLE);

`ifdef OPLL_SEQ_SHADOW_EN
    logic       shadow_we;
    logic [7:0] shadow_q [OPLL_SHADOW_REGS];

    assign shadow_we = (state_reg == ST_HOLD) && ph_reg && (a_reg < 8'h40);

    for (genvar gi = 0; gi < OPLL_SHADOW_REGS; gi++) begin : g_shadow
        logic [7:0] val_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                val_reg <= '0;
            end else if (shadow_we && (a_reg[5:0] == 6'(gi))) begin
                val_reg <= d_reg;
            end
        end
        assign shadow_q[gi] = val_reg;
    end

    assign rd_data = shadow_q[rd_addr];
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Directed bench for opll_write_sequencer: bus timing, queueing, reset abort and shadow reads.
module tb_opll_write_sequencer;
    import opll_seq_pkg::*;

`ifdef OPLL_SEQ_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n, wr_n, a0, busy;
    logic [7:0] d, rd_data;
    logic [5:0] rd_addr = 6'd0;
    logic [3:0] level;

    opll_write_sequencer_if bus();

    opll_write_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus),
        .opll_cs_n  (cs_n),
        .opll_wr_n  (wr_n),
        .opll_a0    (a0),
        .opll_d     (d),
        .busy       (busy),
        .fifo_level (level),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs each WR_n falling edge and each CS_n falling edge.
    typedef struct packed { logic a0; logic [7:0] d; } strobe_t;
    strobe_t    strobes[$];
    int         falls[$];
    int         stab_err = 0;
    logic       p_cs = 1'b1, p_wr = 1'b1, p_a0 = 1'b0;
    logic [7:0] p_d = 8'h00;

    always @(posedge clk) begin
        #2;
        if (!wr_n && p_wr) strobes.push_back({a0, d});
        if (!cs_n && p_cs) falls.push_back(cyc);
        if (!cs_n && !p_cs && ({a0, d} != {p_a0, p_d})) stab_err++;
        if (!wr_n && cs_n) stab_err++;
        p_cs = cs_n; p_wr = wr_n; p_a0 = a0; p_d = d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_one(input logic [7:0] a, input logic [7:0] dd);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = dd;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_writes(input string tag, input opll_wr_t exp[$]);
        logic [17:0] act;
        check({tag, "_count"}, strobes.size(), 2 * exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            act = 18'h3FFFF;
            if (2 * i + 1 < strobes.size()) act = {strobes[2*i], strobes[2*i+1]};
            check($sformatf("%s_w%0d", tag, i), {14'd0, act},
                  {14'd0, 1'b0, exp[i].addr, 1'b1, exp[i].data});
        end
    endtask

    typedef struct {
        int         k0;
        int         k1;
        logic       cs_n;
        logic       wr_n;
        logic       a0;
        logic [7:0] d;
        logic       busy;
    } seg_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_ready;
        logic [3:0] exp_level;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_t       segs[10];
        vec_t       v3[10];
        logic [11:0] tr [0:120];
        opll_wr_t   exp_q[$];
        int         n0, badk, kk;

        segs[0] = '{0,   1,   1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        segs[1] = '{2,   2,   1'b0, 1'b1, 1'b0, 8'h10, 1'b1};
        segs[2] = '{3,   10,  1'b0, 1'b0, 1'b0, 8'h10, 1'b1};
        segs[3] = '{11,  11,  1'b0, 1'b1, 1'b0, 8'h10, 1'b1};
        segs[4] = '{12,  23,  1'b1, 1'b1, 1'b0, 8'h10, 1'b1};
        segs[5] = '{24,  24,  1'b0, 1'b1, 1'b1, 8'hAB, 1'b1};
        segs[6] = '{25,  32,  1'b0, 1'b0, 1'b1, 8'hAB, 1'b1};
        segs[7] = '{33,  33,  1'b0, 1'b1, 1'b1, 8'hAB, 1'b1};
        segs[8] = '{34,  116, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b1};
        segs[9] = '{117, 120, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b0};

        v3[0] = '{8'h20, 8'h01, 1'b1, 4'd1};
        v3[1] = '{8'h21, 8'h12, 1'b1, 4'd1};
        v3[2] = '{8'h22, 8'h23, 1'b1, 4'd2};
        v3[3] = '{8'h23, 8'h34, 1'b1, 4'd3};
        v3[4] = '{8'h24, 8'h45, 1'b1, 4'd4};
        v3[5] = '{8'h25, 8'h56, 1'b1, 4'd5};
        v3[6] = '{8'h26, 8'h67, 1'b1, 4'd6};
        v3[7] = '{8'h27, 8'h78, 1'b1, 4'd7};
        v3[8] = '{8'h38, 8'h89, 1'b1, 4'd8};
        v3[9] = '{8'h77, 8'h9A, 1'b0, 4'd8};

        bus.req_valid = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_data  = 8'h00;

        // 1: reset state
        step(3);
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_wr_n", {31'd0, wr_n}, 32'd1);
        check("rst_a0", {31'd0, a0}, 32'd0);
        check("rst_d", {24'd0, d}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        reset = 1'b0;
        step(1);

        // 2: single write, cycle-by-cycle pin timeline
        strobes.delete(); falls.delete();
        push_one(8'h10, 8'hAB);
        n0 = cyc;
        check("t2_level_after_push", {28'd0, level}, 32'd1);
        for (int k = 0; k <= 120; k++) begin
            tr[k] = {cs_n, wr_n, a0, d, busy};
            step(1);
        end
        for (int s = 0; s < 10; s++) begin
            badk = -1;
            for (int k = segs[s].k0; k <= segs[s].k1; k++)
                if (badk < 0 && tr[k] !== {segs[s].cs_n, segs[s].wr_n, segs[s].a0, segs[s].d, segs[s].busy})
                    badk = k;
            kk = (badk < 0) ? segs[s].k0 : badk;
            check($sformatf("t2_seg%0d_k%0d", s, kk), {20'd0, tr[kk]},
                  {20'd0, segs[s].cs_n, segs[s].wr_n, segs[s].a0, segs[s].d, segs[s].busy});
        end
        exp_q.delete();
        exp_q.push_back(opll_wr_t'({8'h10, 8'hAB}));
        check_writes("t2", exp_q);

        // 3: burst until full, extra push dropped, pairs 116 cycles apart
        strobes.delete(); falls.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_ready%0d", i), {31'd0, bus.req_ready}, {31'd0, v3[i].exp_ready});
            push_one(v3[i].addr, v3[i].data);
            check($sformatf("t3_level%0d", i), {28'd0, level}, {28'd0, v3[i].exp_level});
            if (v3[i].exp_ready) exp_q.push_back(opll_wr_t'({v3[i].addr, v3[i].data}));
        end
        check("t3_first_pair_active", falls.size(), 1);
        wait_idle("t3_idle", 2000);
        check_writes("t3", exp_q);
        check("t3_fall_count", falls.size(), 18);
        for (int i = 0; i < 8; i++) begin
            kk = (2 * i + 2 < falls.size()) ? falls[2*i+2] - falls[2*i] : -1;
            check($sformatf("t3_gap%0d", i), kk, 116);
        end
        check("t3_addr_to_data", (falls.size() > 1) ? falls[1] - falls[0] : -1, 22);

        // 4: push+pop at level 3 holds level; push at full with pop is dropped
        strobes.delete(); falls.delete();
        exp_q.delete();
        push_one(8'h40, 8'hA0);
        n0 = cyc;
        push_one(8'h41, 8'hA1);
        push_one(8'h42, 8'hA2);
        push_one(8'h43, 8'hA3);
        for (int i = 0; i < 4; i++) exp_q.push_back(opll_wr_t'({8'h40 + 8'(i), 8'hA0 + 8'(i)}));
        check("t4_level3", {28'd0, level}, 32'd3);
        while (cyc < n0 + 116) step(1);
        check("t4_level3_before_pop", {28'd0, level}, 32'd3);
        push_one(8'h44, 8'hA4);
        exp_q.push_back(opll_wr_t'({8'h44, 8'hA4}));
        check("t4_push_pop_level", {28'd0, level}, 32'd3);
        for (int i = 5; i < 10; i++) begin
            push_one(8'h40 + 8'(i), 8'hA0 + 8'(i));
            exp_q.push_back(opll_wr_t'({8'h40 + 8'(i), 8'hA0 + 8'(i)}));
        end
        check("t4_full_level", {28'd0, level}, 32'd8);
        check("t4_full_ready", {31'd0, bus.req_ready}, 32'd0);
        while (cyc < n0 + 232) step(1);
        push_one(8'h7F, 8'hEE);
        check("t4_full_push_pop_level", {28'd0, level}, 32'd7);
        wait_idle("t4_idle", 2000);
        check_writes("t4", exp_q);

        // 5: reset during data-phase strobe aborts everything
        strobes.delete(); falls.delete();
        push_one(8'h12, 8'h34);
        n0 = cyc;
        push_one(8'h13, 8'h35);
        while (cyc < n0 + 26) step(1);
        check("t5_in_strobe", {31'd0, wr_n}, 32'd0);
        reset = 1'b1;
        step(1);
        check("t5_wr_n", {31'd0, wr_n}, 32'd1);
        check("t5_cs_n", {31'd0, cs_n}, 32'd1);
        check("t5_level", {28'd0, level}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        strobes.delete(); falls.delete();
        step(200);
        check("t5_no_strobes", strobes.size() + falls.size(), 0);
        push_one(8'h22, 8'h33);
        wait_idle("t5_idle", 400);
        exp_q.delete();
        exp_q.push_back(opll_wr_t'({8'h22, 8'h33}));
        check_writes("t5", exp_q);

        // 6: shadow readback (all zero when the shadow is not built)
        strobes.delete(); falls.delete();
        rd_addr = 6'h30;
        push_one(8'h30, 8'h5C);
        n0 = cyc;
        push_one(8'h45, 8'h11);
        while (cyc < n0 + 32) step(1);
        check("t6_before_hold", {24'd0, rd_data}, 32'd0);
        step(1);
        check("t6_after_hold", {24'd0, rd_data}, SHADOW ? 32'h5C : 32'h0);
        wait_idle("t6_idle", 600);
        rd_addr = 6'h05; #1;
        check("t6_rd05", {24'd0, rd_data}, 32'd0);
        rd_addr = 6'h30; #1;
        check("t6_rd30", {24'd0, rd_data}, SHADOW ? 32'h5C : 32'h0);
        rd_addr = 6'h22; #1;
        check("t6_rd22", {24'd0, rd_data}, SHADOW ? 32'h33 : 32'h0);
        exp_q.delete();
        exp_q.push_back(opll_wr_t'({8'h30, 8'h5C}));
        exp_q.push_back(opll_wr_t'({8'h45, 8'h11}));
        check_writes("t6", exp_q);

        check("bus_stability", stab_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
